// File: rtl/dtw_query_dispatcher.sv
// dtw_query_dispatcher
//
// Takes AXI-Stream queries (one tlast-framed packet per query), picks a free dtw_core lane
// round-robin, and streams exactly SQG_SIZE unpacked samples into that lane's source FIFO.
// Long queries are truncated and short ones are padded by repeating the last sample, or with
// zeros if the query carried no sample at all. A query ID goes out with the lane start pulse.
//
// Ports
//   s00_axis_aclk / s00_axis_aresetn  clock, synchronous active-low reset
//   s00_axis_t*                       AXI-Stream slave; sample lane 0 sits in the LSBs
//   enable                            dispatch enable, looked at only while idle
//   core_busy / core_full             per-lane running / source-FIFO-full status
//   core_start / core_wren            per-lane start pulse / sample write strobe
//   core_data / core_qid              shared sample bus / ID of the query in flight
//   stat_queries/_trunc/_padded       saturating completion counters

module dtw_query_dispatcher #(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned width                  = 16,
    parameter int unsigned NUM_CORES              = 4,
    parameter int unsigned SQG_SIZE               = 250,
    parameter int unsigned QID_WIDTH              = 8
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    output logic                                s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                                s00_axis_tlast,
    input  logic                                s00_axis_tvalid,
    input  logic                                enable,
    input  logic [NUM_CORES-1:0]                core_busy,
    input  logic [NUM_CORES-1:0]                core_full,
    output logic [NUM_CORES-1:0]                core_start,
    output logic [NUM_CORES-1:0]                core_wren,
    output logic [width-1:0]                    core_data,
    output logic [QID_WIDTH-1:0]                core_qid,
    output logic [31:0]                         stat_queries,
    output logic [15:0]                         stat_trunc,
    output logic [15:0]                         stat_padded
);

    localparam int unsigned Spw   = C_S00_AXIS_TDATA_WIDTH / width;
    localparam int unsigned Bpl   = width / 8;
    localparam int unsigned CurW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned LaneW = (Spw > 1) ? $clog2(Spw) : 1;
    localparam int unsigned CntW  = $clog2(SQG_SIZE + 1);
    localparam logic [CntW-1:0] SqgCnt   = CntW'(SQG_SIZE);
    localparam logic [CurW-1:0] LastCore = CurW'(NUM_CORES - 1);

    typedef enum logic [2:0] {StIdle, StStart, StStream, StPad, StDone} state_e;

    state_e                              state_q, state_d;
    logic [CurW-1:0]                     cur_q, cur_d;
    logic [CurW-1:0]                     rr_q, rr_d;
    logic [QID_WIDTH-1:0]                qid_q, qid_d;
    logic [CntW-1:0]                     cnt_q, cnt_d;
    logic [width-1:0]                    last_q, last_d;
    logic                                trunc_q, trunc_d;
    logic                                padded_q, padded_d;
    logic                                buf_full_q, buf_full_d;
    logic [Spw-1:0]                      buf_mask_q, buf_mask_d;
    logic                                buf_last_q, buf_last_d;
    logic [C_S00_AXIS_TDATA_WIDTH-1:0]   buf_data_q, buf_data_d;
    logic [width-1:0]                    data_q, data_d;
    logic [31:0]                         stat_queries_q, stat_queries_d;
    logic [15:0]                         stat_trunc_q, stat_trunc_d;
    logic [15:0]                         stat_padded_q, stat_padded_d;

    logic                                pick_found;
    logic [CurW-1:0]                     pick_idx;
    logic                                sel_found;
    logic [LaneW-1:0]                    sel_idx;
    logic [width-1:0]                    sel_sample;
    logic [Spw-1:0]                      mask_rest;
    logic [Spw-1:0]                      strb_mask;
    logic                                start_pulse;
    logic                                wr_en;
    logic [width-1:0]                    wr_data;

    // First free lane at or after the round-robin pointer, wrapping.
    always_comb begin
        int unsigned idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idx = (32'(rr_q) + i) % NUM_CORES;
            if (!pick_found && !core_busy[CurW'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = CurW'(idx);
            end
        end
    end

    // Lowest pending lane of the buffered word; invalid lanes were never marked pending.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_sample = '0;
        mask_rest  = buf_mask_q;
        for (int unsigned l = 0; l < Spw; l++) begin
            if (!sel_found && buf_mask_q[l]) begin
                sel_found    = 1'b1;
                sel_idx      = LaneW'(l);
                sel_sample   = buf_data_q[l*width +: width];
                mask_rest[l] = 1'b0;
            end
        end
    end

    // A lane counts only when every one of its byte strobes is set.
    always_comb begin
        strb_mask = '0;
        for (int unsigned l = 0; l < Spw; l++) begin
            strb_mask[l] = &s00_axis_tstrb[l*Bpl +: Bpl];
        end
    end

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        rr_d           = rr_q;
        qid_d          = qid_q;
        cnt_d          = cnt_q;
        last_d         = last_q;
        trunc_d        = trunc_q;
        padded_d       = padded_q;
        buf_full_d     = buf_full_q;
        buf_mask_d     = buf_mask_q;
        buf_last_d     = buf_last_q;
        buf_data_d     = buf_data_q;
        stat_queries_d = stat_queries_q;
        stat_trunc_d   = stat_trunc_q;
        stat_padded_d  = stat_padded_q;
        s00_axis_tready = 1'b0;
        start_pulse    = 1'b0;
        wr_en          = 1'b0;
        wr_data        = last_q;

        unique case (state_q)
            StIdle: begin
                if (enable && pick_found) begin
                    cur_d   = pick_idx;
                    state_d = StStart;
                end
            end
            StStart: begin
                start_pulse = 1'b1;
                cnt_d       = '0;
                last_d      = '0;
                trunc_d     = 1'b0;
                padded_d    = 1'b0;
                state_d     = StStream;
            end
            StStream: begin
                s00_axis_tready = !buf_full_q;
                if (!buf_full_q) begin
                    if (s00_axis_tvalid) begin
                        buf_full_d = 1'b1;
                        buf_data_d = s00_axis_tdata;
                        buf_mask_d = strb_mask;
                        buf_last_d = s00_axis_tlast;
                    end
                end else if (!sel_found) begin
                    // Word with no valid lane: drained in a single cycle.
                    buf_full_d = 1'b0;
                    if (buf_last_q) begin
                        state_d = (cnt_q < SqgCnt) ? StPad : StDone;
                    end
                end else if (!core_full[cur_q]) begin
                    if (cnt_q < SqgCnt) begin
                        wr_en   = 1'b1;
                        wr_data = sel_sample;
                        cnt_d   = cnt_q + 1'b1;
                        last_d  = sel_sample;
                    end else begin
                        trunc_d = 1'b1;
                    end
                    buf_mask_d = mask_rest;
                    if (mask_rest == '0) begin
                        buf_full_d = 1'b0;
                        if (buf_last_q) begin
                            state_d = (cnt_d < SqgCnt) ? StPad : StDone;
                        end
                    end
                end
            end
            StPad: begin
                padded_d = 1'b1;
                if (!core_full[cur_q]) begin
                    wr_en   = 1'b1;
                    wr_data = last_q;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_d == SqgCnt) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (stat_queries_q != '1) stat_queries_d = stat_queries_q + 1'b1;
                if (trunc_q && stat_trunc_q != '1) stat_trunc_d = stat_trunc_q + 1'b1;
                if (padded_q && stat_padded_q != '1) stat_padded_d = stat_padded_q + 1'b1;
                qid_d   = qid_q + 1'b1;
                rr_d    = (cur_q == LastCore) ? '0 : cur_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // The shared bus keeps the last written sample between writes.
    always_comb begin
        data_d        = wr_en ? wr_data : data_q;
        core_data     = data_d;
        core_start    = '0;
        core_start[cur_q] = start_pulse;
        core_wren     = '0;
        core_wren[cur_q]  = wr_en;
        core_qid      = qid_q;
        stat_queries  = stat_queries_q;
        stat_trunc    = stat_trunc_q;
        stat_padded   = stat_padded_q;
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state_q        <= StIdle;
            cur_q          <= '0;
            rr_q           <= '0;
            qid_q          <= '0;
            cnt_q          <= '0;
            last_q         <= '0;
            trunc_q        <= 1'b0;
            padded_q       <= 1'b0;
            buf_full_q     <= 1'b0;
            buf_mask_q     <= '0;
            buf_last_q     <= 1'b0;
            buf_data_q     <= '0;
            data_q         <= '0;
            stat_queries_q <= '0;
            stat_trunc_q   <= '0;
            stat_padded_q  <= '0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            rr_q           <= rr_d;
            qid_q          <= qid_d;
            cnt_q          <= cnt_d;
            last_q         <= last_d;
            trunc_q        <= trunc_d;
            padded_q       <= padded_d;
            buf_full_q     <= buf_full_d;
            buf_mask_q     <= buf_mask_d;
            buf_last_q     <= buf_last_d;
            buf_data_q     <= buf_data_d;
            data_q         <= data_d;
            stat_queries_q <= stat_queries_d;
            stat_trunc_q   <= stat_trunc_d;
            stat_padded_q  <= stat_padded_d;
        end
    end

endmodule

// File: tb/tb_dtw_query_dispatcher.sv
// Scoreboard bench for dtw_query_dispatcher: stimulus pushes expected starts and samples,
// a negedge monitor pops and compares whenever the DUT pulses core_start or core_wren.
`timescale 1ns/1ps

module tb_dtw_query_dispatcher;

    localparam int unsigned TW  = 32;
    localparam int unsigned W   = 16;
    localparam int unsigned NC  = 4;
    localparam int unsigned SQG = 250;
    localparam int unsigned QW  = 8;
    localparam int unsigned SPW = TW / W;
    localparam int unsigned BPL = W / 8;

    logic            clk = 1'b0;
    logic            aresetn;
    logic            tready;
    logic [TW-1:0]   tdata;
    logic [TW/8-1:0] tstrb;
    logic            tlast;
    logic            tvalid;
    logic            enable;
    logic [NC-1:0]   core_busy;
    logic [NC-1:0]   core_full;
    logic [NC-1:0]   core_start;
    logic [NC-1:0]   core_wren;
    logic [W-1:0]    core_data;
    logic [QW-1:0]   core_qid;
    logic [31:0]     stat_queries;
    logic [15:0]     stat_trunc;
    logic [15:0]     stat_padded;

    always #5 clk = ~clk;

    dtw_query_dispatcher #(
        .C_S00_AXIS_TDATA_WIDTH(TW),
        .width(W),
        .NUM_CORES(NC),
        .SQG_SIZE(SQG),
        .QID_WIDTH(QW)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(aresetn),
        .s00_axis_tready(tready),
        .s00_axis_tdata(tdata),
        .s00_axis_tstrb(tstrb),
        .s00_axis_tlast(tlast),
        .s00_axis_tvalid(tvalid),
        .enable(enable),
        .core_busy(core_busy),
        .core_full(core_full),
        .core_start(core_start),
        .core_wren(core_wren),
        .core_data(core_data),
        .core_qid(core_qid),
        .stat_queries(stat_queries),
        .stat_trunc(stat_trunc),
        .stat_padded(stat_padded)
    );

    int checks = 0;
    int failures = 0;

    // Scoreboard queues and reference-model state
    logic [W-1:0]    exp_data_q[$];
    int              exp_lane_q[$];
    int              exp_qid_q[$];
    int              m_rr, m_qid, m_queries, m_trunc, m_padded;

    // Current query's words
    logic [TW-1:0]   q_data[$];
    logic [TW/8-1:0] q_strb[$];

    // Monitor state
    bit              mon_en = 1'b0;
    int              cur_lane = -1;
    logic [W-1:0]    last_data = '0;
    int              wren_count = 0;
    int              start_count = 0;
    int              mon_lane, mon_qid;
    logic [W-1:0]    mon_d;

    bit              rand_full = 1'b0;
    bit              force_full = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (core_start != '0) begin
                start_count++;
                if (exp_lane_q.size() == 0) begin
                    check("unexpected_start", 64'(core_start), 64'd0);
                end else begin
                    mon_lane = exp_lane_q.pop_front();
                    mon_qid  = exp_qid_q.pop_front();
                    cur_lane = mon_lane;
                    check("start_lane", 64'(core_start), 64'(1) << mon_lane);
                    check("start_qid", 64'(core_qid), 64'(mon_qid));
                end
            end
            if (core_wren != '0) begin
                wren_count++;
                check("wren_lane", 64'(core_wren), (cur_lane >= 0) ? (64'(1) << cur_lane) : 64'd0);
                check("wren_while_full", 64'(core_wren & core_full), 64'd0);
                if (exp_data_q.size() == 0) begin
                    check("extra_wren", 64'(core_wren), 64'd0);
                end else begin
                    mon_d = exp_data_q.pop_front();
                    last_data = mon_d;
                    check("wr_data", 64'(core_data), 64'(mon_d));
                end
            end else begin
                check("data_hold", 64'(core_data), 64'(last_data));
            end
        end
    end

    // Back-pressure from the lanes: random, forced all-full, or off.
    initial begin
        core_full = '0;
        forever begin
            @(posedge clk);
            #1;
            if (force_full) core_full = '1;
            else if (rand_full) core_full = NC'($urandom & $urandom);
            else core_full = '0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic flush_model();
        exp_data_q.delete();
        exp_lane_q.delete();
        exp_qid_q.delete();
        m_rr = 0; m_qid = 0; m_queries = 0; m_trunc = 0; m_padded = 0;
        cur_lane = -1;
        last_data = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tready"}, 64'(tready), 64'd0);
        check({tag, "_start"}, 64'(core_start), 64'd0);
        check({tag, "_wren"}, 64'(core_wren), 64'd0);
        check({tag, "_data"}, 64'(core_data), 64'd0);
        check({tag, "_qid"}, 64'(core_qid), 64'd0);
        check({tag, "_stat_q"}, 64'(stat_queries), 64'd0);
        check({tag, "_stat_t"}, 64'(stat_trunc), 64'd0);
        check({tag, "_stat_p"}, 64'(stat_padded), 64'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        aresetn = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("reset");
        aresetn = 1'b1;
        flush_model();
    endtask

    task automatic build(input int n, input bit rnd_strb);
        logic [TW/8-1:0] s;
        q_data.delete();
        q_strb.delete();
        for (int i = 0; i < n; i++) begin
            s = '1;
            if (rnd_strb && ($urandom % 6 == 0)) s = (TW/8)'($urandom);
            q_data.push_back(TW'($urandom));
            q_strb.push_back(s);
        end
    endtask

    // Reference: valid lanes in order, cut to SQG, padded with the last sample (or 0).
    task automatic model_query(input logic [NC-1:0] busy);
        logic [W-1:0]    s[$];
        logic [W-1:0]    lastv;
        logic [TW-1:0]   wd;
        logic [TW/8-1:0] ws;
        int              lane;
        bit              tr, pd;
        for (int i = 0; i < q_data.size(); i++) begin
            wd = q_data[i];
            ws = q_strb[i];
            for (int l = 0; l < SPW; l++) begin
                if (&ws[l*BPL +: BPL]) s.push_back(wd[l*W +: W]);
            end
        end
        tr = s.size() > SQG;
        while (s.size() > SQG) void'(s.pop_back());
        pd = s.size() < SQG;
        lastv = (s.size() > 0) ? s[s.size()-1] : '0;
        while (s.size() < SQG) s.push_back(lastv);
        lane = -1;
        for (int i = 0; i < NC; i++) begin
            if (lane < 0 && !busy[(m_rr + i) % NC]) lane = (m_rr + i) % NC;
        end
        exp_lane_q.push_back(lane);
        exp_qid_q.push_back(m_qid);
        foreach (s[k]) exp_data_q.push_back(s[k]);
        m_rr = (lane + 1) % NC;
        m_qid = (m_qid + 1) % (1 << QW);
        m_queries++;
        if (tr) m_trunc++;
        if (pd) m_padded++;
    endtask

    task automatic send_word(input logic [TW-1:0] d, input logic [TW/8-1:0] s, input logic l);
        int n = 0;
        logic ok = 1'b0;
        tdata = d; tstrb = s; tlast = l; tvalid = 1'b1;
        while (!ok && n < 2000) begin
            @(negedge clk);
            ok = tready;
            @(posedge clk); #1;
            n++;
        end
        tvalid = 1'b0;
        check("handshake", 64'(ok), 64'd1);
    endtask

    task automatic start_query(input logic [NC-1:0] busy);
        int prev = start_count;
        int n = 0;
        model_query(busy);
        core_busy = busy;
        enable = 1'b1;
        while (start_count == prev && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("start_seen", 64'(start_count != prev), 64'd1);
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic run_query(input logic [NC-1:0] busy, input bit stall);
        logic [31:0] prev_q = stat_queries;
        int first = 0;
        int n = 0;
        start_query(busy);
        if (stall) begin
            force_full = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            send_word(q_data[0], q_strb[0], q_data.size() == 1);
            repeat (5) begin
                @(negedge clk);
                check("stall_no_wren", 64'(core_wren), 64'd0);
                check("stall_tready_low", 64'(tready), 64'd0);
                @(posedge clk); #1;
            end
            force_full = 1'b0;
            first = 1;
        end
        for (int i = first; i < q_data.size(); i++) begin
            send_word(q_data[i], q_strb[i], i == q_data.size() - 1);
        end
        while (stat_queries == prev_q && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("query_done", 64'(stat_queries != prev_q), 64'd1);
        check("stat_queries", 64'(stat_queries), 64'(m_queries));
        check("stat_trunc", 64'(stat_trunc), 64'(m_trunc));
        check("stat_padded", 64'(stat_padded), 64'(m_padded));
        check("samples_left", 64'(exp_data_q.size()), 64'd0);
    endtask

    task automatic reset_mid_stream();
        int base, i, n;
        logic ok;
        bit reached = 1'b0;
        build(130, 1'b0);
        start_query('0);
        base = wren_count;
        i = 0; n = 0;
        tdata = q_data[0]; tstrb = q_strb[0]; tlast = 1'b0; tvalid = 1'b1;
        while (!reached && n < 3000) begin
            @(negedge clk); #1;
            if (wren_count >= base + 37) begin
                reached = 1'b1;
                aresetn = 1'b0;
            end else begin
                ok = tready;
                @(posedge clk); #1;
                n++;
                if (ok) begin
                    i++;
                    if (i < q_data.size()) begin
                        tdata = q_data[i]; tstrb = q_strb[i]; tlast = (i == q_data.size() - 1);
                    end else begin
                        tvalid = 1'b0;
                    end
                end
            end
        end
        tvalid = 1'b0;
        check("reset_point", 64'(reached), 64'd1);
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        aresetn = 1'b1;
        flush_model();
        repeat (4) begin @(posedge clk); #1; end
        check("writes_before_reset", 64'(wren_count - base), 64'd37);
    endtask

    initial begin
        logic [TW-1:0] tmp;
        logic [NC-1:0] busy;
        aresetn = 1'b0; tdata = '0; tstrb = '0; tlast = 1'b0; tvalid = 1'b0;
        enable = 1'b0; core_busy = '0;
        flush_model();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("init");
        aresetn = 1'b1;
        mon_en = 1'b1;

        // Three full-length queries to lanes 0,1,2
        repeat (3) begin
            build(125, 1'b0);
            run_query('0, 1'b0);
        end

        // Over-long query gets truncated
        rand_full = 1'b1;
        build(130, 1'b0);
        run_query('0, 1'b0);

        // Short query padded with its final sample
        build(100, 1'b0);
        tmp = q_data[99];
        tmp[31:16] = 16'h1234;
        q_data[99] = tmp;
        run_query('0, 1'b0);

        // Partial strobes mid-query, then a lone all-invalid tlast word
        build(125, 1'b0);
        q_strb[50] = 4'b1100;
        run_query('0, 1'b0);
        q_data.delete();
        q_strb.delete();
        q_data.push_back(TW'($urandom));
        q_strb.push_back('0);
        run_query('0, 1'b0);

        // Busy lanes skipped from a fresh pointer; then a stalled lane
        apply_reset();
        build(125, 1'b0);
        run_query(4'b0101, 1'b0);
        build(125, 1'b0);
        run_query(4'b0101, 1'b0);
        build(110, 1'b0);
        run_query('0, 1'b1);

        // Reset in the middle of a query, then restart from lane 0 / qid 0
        reset_mid_stream();
        build(125, 1'b0);
        run_query('0, 1'b0);

        // Randomised tail
        repeat (4) begin
            build(90 + int'($urandom % 50), 1'b1);
            busy = NC'($urandom);
            if (busy == '1) busy[$urandom % NC] = 1'b0;
            run_query(busy, 1'b0);
        end

        rand_full = 1'b0;
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
